mem_loader: RTL

// - Boot-time stage directly upstream of the 64 KiB system memory. Consumes a framed

---
 rtl/mem_loader_pkg.sv | 31 +++
 rtl/mem_loader_timeout.sv | 56 +++++
 rtl/mem_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader_pkg
// Purpose  : Shared types and constants for the boot-time memory loader.
// Revision : 1.0 - initial release
// ============================================================================
package mem_loader_pkg;

  // Loader parser states; RUN is terminal until reset.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AHI  = 3'd1,
    LLO  = 3'd2,
    LHI  = 3'd3,
    DATA = 3'd4,
    CSUM = 3'd5,
    RUN  = 3'd6
  } state_e;

  // Header is ADDR_LO, ADDR_HI, LEN_LO, LEN_HI.
  localparam int         HDR_BYTES = 4;
  // Running 8-bit sum of a good frame, checksum byte included.
  localparam logic [7:0] CSUM_GOOD = 8'h00;

  // Modulo-256 checksum accumulation.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_loader_timeout.sv
`default_nettype none
// ============================================================================
// Module   : loader_timeout
// Purpose  : Idle-cycle counter with clear, enable and terminal-count pulse.
//            tc_o fires in the cycle the count would reach TIMEOUT; a clear in
//            that same cycle suppresses it. TIMEOUT = 0 disables the pulse.
// Revision : 1.0 - initial release
// ============================================================================
module loader_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = clk_i ^ rst_ni ^ clr_i ^ en_i;
      assign tc_o          = 1'b0;
    end else begin : g_counter
      localparam int CNT_W = $clog2(TIMEOUT + 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             tc;

      assign tc   = en_i & ~clr_i & (cnt_q == CNT_W'(TIMEOUT - 1));
      assign tc_o = tc;

      // Next count: clear wins, restart after a terminal count, else count up.
      always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tc) begin
          cnt_d = '0;
        end else if (en_i) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Count register.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Purpose  : Parses framed byte stream (addr, len, data, checksum) into system
//            memory writes while the CPU is stalled; a good zero-length frame
//            releases the CPU and turns the block into a bus pass-through.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  input  logic [ADDR_W-1:0] CpuAddress,
  input  logic              CpuWE,
  input  logic [7:0]        CpuDataOut,
  output logic [ADDR_W-1:0] MemAddress,
  output logic              MemWE,
  output logic [7:0]        MemDataIn,
  output logic              CpuRun,
  output logic              FrameOk,
  output logic              FrameErr
);

  state_e            state_q,     state_d;
  logic [7:0]        lo_q,        lo_d;        // low byte of addr/len header field
  logic [ADDR_W-1:0] addr_q,      addr_d;      // current load address
  logic [15:0]       len_q,       len_d;       // data bytes still expected
  logic [7:0]        sum_q,       sum_d;       // running checksum
  logic              start_q,     start_d;     // frame has LEN == 0
  logic              wr_q,        wr_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [7:0]        wr_data_q,   wr_data_d;
  logic              ok_q,        ok_d;
  logic              err_q,       err_d;
  logic              run_q,       run_d;

  logic        xfer;
  logic        to_active;
  logic        to_tc;
  logic [7:0]  sum_next;
  logic [15:0] hdr_word;

  assign RxReady   = (state_q != RUN);
  assign xfer      = RxValid & RxReady;
  assign to_active = (state_q != IDLE) && (state_q != RUN);
  assign sum_next  = csum_add(sum_q, RxData);
  assign hdr_word  = {RxData, lo_q};

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .clr_i  (xfer | ~to_active),
    .en_i   (to_active),
    .tc_o   (to_tc)
  );

  // Parser next-state: header capture, data writes, checksum verdict, timeout.
  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    addr_d    = addr_q;
    len_d     = len_q;
    sum_d     = sum_q;
    start_d   = start_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    run_d     = run_q;

    if (xfer) begin
      sum_d = sum_next;
      unique case (state_q)
        IDLE: begin
          lo_d    = RxData;
          sum_d   = RxData;
          state_d = AHI;
        end
        AHI: begin
          addr_d  = ADDR_W'(hdr_word);
          state_d = LLO;
        end
        LLO: begin
          lo_d    = RxData;
          state_d = LHI;
        end
        LHI: begin
          len_d   = hdr_word;
          start_d = (hdr_word == 16'd0);
          state_d = (hdr_word == 16'd0) ? CSUM : DATA;
        end
        DATA: begin
          wr_d      = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = RxData;
          addr_d    = addr_q + ADDR_W'(1);
          len_d     = len_q - 16'd1;
          if (len_q == 16'd1) begin
            state_d = CSUM;
          end
        end
        CSUM: begin
          if (sum_next == CSUM_GOOD) begin
            ok_d = 1'b1;
            if (start_q) begin
              state_d = RUN;
              run_d   = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (to_tc) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  // Parser and loader-side output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      start_q   <= 1'b0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      start_q   <= start_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      run_q     <= run_d;
    end
  end

  // Memory port ownership: CPU bus straight through once released.
  always_comb begin
    MemAddress = wr_addr_q;
    MemWE      = wr_q;
    MemDataIn  = wr_data_q;
    if (state_q == RUN) begin
      MemAddress = CpuAddress;
      MemWE      = CpuWE;
      MemDataIn  = CpuDataOut;
    end
  end

  assign CpuRun   = run_q;
  assign FrameOk  = ok_q;
  assign FrameErr = err_q;

endmodule
`default_nettype wire
